// File: rtl/transactions_rx_fsm.sv
// Sideband receive-side transaction parser: deserializes 10-bit SBRX frames,
// recognizes DLE/STX/LSE/CLSE/ETX framing, checks CRC-16 and reports results.
module transactions_rx_fsm (
    input  logic        sb_clk,
    input  logic        rst,
    input  logic        sbrx_i,
    input  logic        rx_en_i,
    output logic [2:0]  trans_rcvd_o,
    output logic [7:0]  at_addr_o,
    output logic [7:0]  at_len_o,
    output logic [23:0] at_data_o,
    output logic        crc_err_o,
    output logic        frame_err_o,
    output logic        parse_err_o,
    output logic        rx_busy_o
);

    localparam logic [7:0] SymDle    = 8'hFE;
    localparam logic [7:0] SymStxCmd = 8'h05;
    localparam logic [7:0] SymStxRsp = 8'h04;
    localparam logic [7:0] SymLse    = 8'h80;
    localparam logic [7:0] SymClse   = 8'h7F;
    localparam logic [7:0] SymEtx    = 8'h40;
    localparam logic [7:0] AtLen     = 8'h03;

    typedef enum logic {RxIdle, RxBits} rx_state_e;

    typedef enum logic [3:0] {
        PIdle, PDle1, PLse, PCmdAddr, PCmdLen, PRspAddr, PRspLen,
        PRspD0, PRspD1, PRspD2, PCrcHi, PCrcLo, PDle2, PEtx
    } p_state_e;

    rx_state_e   rx_state_q, rx_state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        sym_valid_q, sym_valid_d;
    logic        sym_ferr_q, sym_ferr_d;

    p_state_e    p_state_q, p_state_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] rcv_crc_q, rcv_crc_d;
    logic [7:0]  sh_addr_q, sh_addr_d;
    logic [7:0]  sh_len_q, sh_len_d;
    logic [23:0] sh_data_q, sh_data_d;
    logic        is_rsp_q, is_rsp_d;
    logic [2:0]  trans_q, trans_d;
    logic [7:0]  at_addr_q, at_addr_d;
    logic [7:0]  at_len_q, at_len_d;
    logic [23:0] at_data_q, at_data_d;
    logic        crc_err_q, crc_err_d;
    logic        frame_err_q, frame_err_d;
    logic        parse_err_q, parse_err_d;

    // CRC-16/0x8005 update with one byte, MSB first
    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            r = (r[15] ^ b[i]) ? ({r[14:0], 1'b0} ^ 16'h8005) : {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // Deserializer next state: start bit, 8 data bits LSB first, stop bit
    always_comb begin
        rx_state_d  = rx_state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        sym_valid_d = 1'b0;
        sym_ferr_d  = 1'b0;
        if (!rx_en_i) begin
            rx_state_d = RxIdle;
            bit_cnt_d  = 4'd0;
        end else begin
            case (rx_state_q)
                RxIdle: begin
                    if (!sbrx_i) begin
                        rx_state_d = RxBits;
                        bit_cnt_d  = 4'd1;
                    end
                end
                RxBits: begin
                    if (bit_cnt_q == 4'd9) begin
                        rx_state_d  = RxIdle;
                        bit_cnt_d   = 4'd0;
                        sym_valid_d = sbrx_i;
                        sym_ferr_d  = ~sbrx_i;
                    end else begin
                        shift_d   = {sbrx_i, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                default: rx_state_d = RxIdle;
            endcase
        end
    end

    // Parser next state, shadow capture, CRC accumulation and result pulses
    always_comb begin
        p_state_d   = p_state_q;
        crc_d       = crc_q;
        rcv_crc_d   = rcv_crc_q;
        sh_addr_d   = sh_addr_q;
        sh_len_d    = sh_len_q;
        sh_data_d   = sh_data_q;
        is_rsp_d    = is_rsp_q;
        at_addr_d   = at_addr_q;
        at_len_d    = at_len_q;
        at_data_d   = at_data_q;
        trans_d     = 3'd0;
        crc_err_d   = 1'b0;
        frame_err_d = 1'b0;
        parse_err_d = 1'b0;
        if (!rx_en_i) begin
            p_state_d = PIdle;
        end else if (sym_ferr_q) begin
            // A broken frame aborts whatever was in progress
            frame_err_d = 1'b1;
            p_state_d   = PIdle;
        end else if (sym_valid_q) begin
            case (p_state_q)
                PIdle: begin
                    if (shift_q == SymDle) begin
                        p_state_d = PDle1;
                        crc_d     = 16'hFFFF;
                    end
                end
                PDle1: begin
                    if (shift_q == SymStxCmd || shift_q == SymStxRsp) begin
                        is_rsp_d  = (shift_q == SymStxRsp);
                        crc_d     = crc_upd(crc_q, shift_q);
                        p_state_d = (shift_q == SymStxRsp) ? PRspAddr : PCmdAddr;
                    end else if (shift_q == SymLse) begin
                        p_state_d = PLse;
                    end else begin
                        parse_err_d = 1'b1;
                        p_state_d   = PIdle;
                    end
                end
                PLse: begin
                    if (shift_q == SymClse) trans_d = 3'd4;
                    else                    parse_err_d = 1'b1;
                    p_state_d = PIdle;
                end
                PCmdAddr, PRspAddr: begin
                    sh_addr_d = shift_q;
                    crc_d     = crc_upd(crc_q, shift_q);
                    p_state_d = (p_state_q == PRspAddr) ? PRspLen : PCmdLen;
                end
                PCmdLen, PRspLen: begin
                    if (shift_q == AtLen) begin
                        sh_len_d  = shift_q;
                        crc_d     = crc_upd(crc_q, shift_q);
                        p_state_d = (p_state_q == PRspLen) ? PRspD0 : PCrcHi;
                    end else begin
                        parse_err_d = 1'b1;
                        p_state_d   = PIdle;
                    end
                end
                PRspD0: begin
                    sh_data_d[23:16] = shift_q;
                    crc_d            = crc_upd(crc_q, shift_q);
                    p_state_d        = PRspD1;
                end
                PRspD1: begin
                    sh_data_d[15:8] = shift_q;
                    crc_d           = crc_upd(crc_q, shift_q);
                    p_state_d       = PRspD2;
                end
                PRspD2: begin
                    sh_data_d[7:0] = shift_q;
                    crc_d          = crc_upd(crc_q, shift_q);
                    p_state_d      = PCrcHi;
                end
                PCrcHi: begin
                    rcv_crc_d[15:8] = shift_q;
                    p_state_d       = PCrcLo;
                end
                PCrcLo: begin
                    rcv_crc_d[7:0] = shift_q;
                    p_state_d      = PDle2;
                end
                PDle2: begin
                    if (shift_q == SymDle) begin
                        p_state_d = PEtx;
                    end else begin
                        parse_err_d = 1'b1;
                        p_state_d   = PIdle;
                    end
                end
                PEtx: begin
                    if (shift_q != SymEtx) begin
                        parse_err_d = 1'b1;
                    end else if (crc_q == rcv_crc_q) begin
                        trans_d   = is_rsp_q ? 3'd3 : 3'd2;
                        at_addr_d = sh_addr_q;
                        at_len_d  = sh_len_q;
                        if (is_rsp_q) at_data_d = sh_data_q;
                    end else begin
                        crc_err_d = 1'b1;
                    end
                    p_state_d = PIdle;
                end
                default: p_state_d = PIdle;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            rx_state_q  <= RxIdle;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            sym_valid_q <= 1'b0;
            sym_ferr_q  <= 1'b0;
            p_state_q   <= PIdle;
            crc_q       <= 16'hFFFF;
            rcv_crc_q   <= 16'd0;
            sh_addr_q   <= 8'd0;
            sh_len_q    <= 8'd0;
            sh_data_q   <= 24'd0;
            is_rsp_q    <= 1'b0;
            trans_q     <= 3'd0;
            at_addr_q   <= 8'd0;
            at_len_q    <= 8'd0;
            at_data_q   <= 24'd0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            parse_err_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            sym_valid_q <= sym_valid_d;
            sym_ferr_q  <= sym_ferr_d;
            p_state_q   <= p_state_d;
            crc_q       <= crc_d;
            rcv_crc_q   <= rcv_crc_d;
            sh_addr_q   <= sh_addr_d;
            sh_len_q    <= sh_len_d;
            sh_data_q   <= sh_data_d;
            is_rsp_q    <= is_rsp_d;
            trans_q     <= trans_d;
            at_addr_q   <= at_addr_d;
            at_len_q    <= at_len_d;
            at_data_q   <= at_data_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            parse_err_q <= parse_err_d;
        end
    end

    assign trans_rcvd_o = trans_q;
    assign at_addr_o    = at_addr_q;
    assign at_len_o     = at_len_q;
    assign at_data_o    = at_data_q;
    assign crc_err_o    = crc_err_q;
    assign frame_err_o  = frame_err_q;
    assign parse_err_o  = parse_err_q;
    assign rx_busy_o    = (p_state_q != PIdle);

endmodule

// File: tb/tb_transactions_rx_fsm.sv
// Randomized self-checking bench for transactions_rx_fsm with a frame-level reference model.
module tb_transactions_rx_fsm;

    typedef logic [7:0] byte_q_t[$];

    logic        sb_clk = 1'b0;
    logic        rst;
    logic        sbrx;
    logic        rx_en;
    logic [2:0]  trans_rcvd;
    logic [7:0]  at_addr;
    logic [7:0]  at_len;
    logic [23:0] at_data;
    logic        crc_err;
    logic        frame_err;
    logic        parse_err;
    logic        rx_busy;

    int checks = 0;
    int errors = 0;

    // Pulse monitor counters, written only by the monitor process
    int n_trans = 0, n_crc = 0, n_parse = 0, n_frame = 0, n_multi = 0, n_wide = 0;
    logic [2:0] last_trans = 3'd0;
    logic [2:0] prev_trans = 3'd0;
    logic prev_crc = 1'b0, prev_parse = 1'b0, prev_frame = 1'b0;

    // Snapshots taken at the start of each scenario
    int s_trans, s_crc, s_parse, s_frame;

    // Reference model of the held payload registers
    logic [7:0]  exp_addr = 8'd0;
    logic [7:0]  exp_len  = 8'd0;
    logic [23:0] exp_data = 24'd0;

    always #5 sb_clk = ~sb_clk;

    transactions_rx_fsm dut (
        .sb_clk      (sb_clk),
        .rst         (rst),
        .sbrx_i      (sbrx),
        .rx_en_i     (rx_en),
        .trans_rcvd_o(trans_rcvd),
        .at_addr_o   (at_addr),
        .at_len_o    (at_len),
        .at_data_o   (at_data),
        .crc_err_o   (crc_err),
        .frame_err_o (frame_err),
        .parse_err_o (parse_err),
        .rx_busy_o   (rx_busy)
    );

    // Counts pulses, flags simultaneous results and pulses wider than one cycle
    always @(negedge sb_clk) begin
        if (rst) begin
            if (trans_rcvd != 3'd0) begin
                n_trans    <= n_trans + 1;
                last_trans <= trans_rcvd;
            end
            if (crc_err)   n_crc   <= n_crc + 1;
            if (parse_err) n_parse <= n_parse + 1;
            if (frame_err) n_frame <= n_frame + 1;
            if ((32'(trans_rcvd != 3'd0) + 32'(crc_err) + 32'(parse_err) + 32'(frame_err)) > 1)
                n_multi <= n_multi + 1;
            if ((trans_rcvd != 3'd0 && prev_trans != 3'd0) || (crc_err && prev_crc) ||
                (parse_err && prev_parse) || (frame_err && prev_frame))
                n_wide <= n_wide + 1;
        end
        prev_trans <= rst ? trans_rcvd : 3'd0;
        prev_crc   <= rst & crc_err;
        prev_parse <= rst & parse_err;
        prev_frame <= rst & frame_err;
    end

    // CRC-16, poly 0x8005, init 0xFFFF, processed as one long MSB-first bit stream
    function automatic logic [15:0] ref_crc(input byte_q_t b);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (b[i]) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[15] ^ b[i][k];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        end
        return c;
    endfunction

    function automatic byte_q_t build_at(input bit rsp, input logic [7:0] addr,
                                         input logic [23:0] data, input bit bad);
        byte_q_t cov, f;
        logic [15:0] c;
        cov.push_back(rsp ? 8'h04 : 8'h05);
        cov.push_back(addr);
        cov.push_back(8'h03);
        if (rsp) begin
            cov.push_back(data[23:16]);
            cov.push_back(data[15:8]);
            cov.push_back(data[7:0]);
        end
        c = ref_crc(cov);
        if (bad) c[7:0] = c[7:0] ^ 8'h01;
        f.push_back(8'hFE);
        foreach (cov[i]) f.push_back(cov[i]);
        f.push_back(c[15:8]);
        f.push_back(c[7:0]);
        f.push_back(8'hFE);
        f.push_back(8'h40);
        return f;
    endfunction

    task automatic send_bit(input logic b);
        @(negedge sb_clk);
        sbrx = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic send_frame(input byte_q_t f, input bit gaps);
        foreach (f[i]) begin
            send_byte(f[i], 1'b1);
            if (gaps) idle($urandom_range(0, 3));
        end
    endtask

    task automatic snap();
        #1;
        s_trans = n_trans;
        s_crc   = n_crc;
        s_parse = n_parse;
        s_frame = n_frame;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        sbrx  = 1'b1;
        rx_en = 1'b1;
        repeat (3) @(posedge sb_clk);
        #1;
        checks++; if (trans_rcvd !== 3'd0) begin errors++; $display("FAIL rst_trans got %0d want 0", trans_rcvd); end
        checks++; if (at_addr !== 8'd0) begin errors++; $display("FAIL rst_addr got %h want 00", at_addr); end
        checks++; if (at_len !== 8'd0) begin errors++; $display("FAIL rst_len got %h want 00", at_len); end
        checks++; if (at_data !== 24'd0) begin errors++; $display("FAIL rst_data got %h want 000000", at_data); end
        checks++; if ({crc_err, frame_err, parse_err} !== 3'b000) begin errors++; $display("FAIL rst_errs got %b want 000", {crc_err, frame_err, parse_err}); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", rx_busy); end
        @(negedge sb_clk);
        rst = 1'b1;
        idle(3);
    endtask

    task automatic test_lt();
        snap();
        send_byte(8'hFE, 1'b1);
        @(posedge sb_clk); @(posedge sb_clk); #1;
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL lt_busy_after_dle got %b want 1", rx_busy); end
        send_byte(8'h80, 1'b1);
        send_byte(8'h7F, 1'b1);
        @(posedge sb_clk); #1;
        checks++; if (trans_rcvd !== 3'd0 || rx_busy !== 1'b1) begin errors++; $display("FAIL lt_early got trans %0d busy %b want 0 1", trans_rcvd, rx_busy); end
        @(posedge sb_clk); #1;
        checks++; if (trans_rcvd !== 3'd4) begin errors++; $display("FAIL lt_pulse got %0d want 4", trans_rcvd); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL lt_busy_end got %b want 0", rx_busy); end
        @(posedge sb_clk); #1;
        checks++; if (trans_rcvd !== 3'd0) begin errors++; $display("FAIL lt_width got %0d want 0", trans_rcvd); end
        idle(3);
        #1;
        checks++; if (n_trans - s_trans !== 1) begin errors++; $display("FAIL lt_count got %0d want 1", n_trans - s_trans); end
    endtask

    task automatic test_at_cmd();
        snap();
        send_frame(build_at(1'b0, 8'h4E, 24'h0, 1'b0), 1'b0);
        idle(4);
        #1;
        exp_addr = 8'h4E;
        exp_len  = 8'h03;
        checks++; if (n_trans - s_trans !== 1 || last_trans !== 3'd2) begin errors++; $display("FAIL cmd_trans got n=%0d code=%0d want n=1 code=2", n_trans - s_trans, last_trans); end
        checks++; if (at_addr !== exp_addr || at_len !== exp_len) begin errors++; $display("FAIL cmd_addr_len got %h/%h want %h/%h", at_addr, at_len, exp_addr, exp_len); end
        checks++; if (at_data !== exp_data) begin errors++; $display("FAIL cmd_data got %h want %h", at_data, exp_data); end
    endtask

    task automatic test_at_rsp();
        snap();
        send_frame(build_at(1'b1, 8'h4E, 24'hA5FE3C, 1'b0), 1'b1);
        idle(4);
        #1;
        exp_data = 24'hA5FE3C;
        checks++; if (n_trans - s_trans !== 1 || last_trans !== 3'd3) begin errors++; $display("FAIL rsp_trans got n=%0d code=%0d want n=1 code=3", n_trans - s_trans, last_trans); end
        checks++; if (at_data !== exp_data) begin errors++; $display("FAIL rsp_data got %h want %h", at_data, exp_data); end
        checks++; if (n_parse - s_parse !== 0) begin errors++; $display("FAIL rsp_no_parse got %0d want 0", n_parse - s_parse); end
    endtask

    task automatic test_crc_err();
        snap();
        send_frame(build_at(1'b1, 8'h4E, 24'h123456, 1'b1), 1'b0);
        idle(4);
        #1;
        checks++; if (n_crc - s_crc !== 1) begin errors++; $display("FAIL crc_pulse got %0d want 1", n_crc - s_crc); end
        checks++; if (n_trans - s_trans !== 0 || n_parse - s_parse !== 0) begin errors++; $display("FAIL crc_only got trans %0d parse %0d want 0 0", n_trans - s_trans, n_parse - s_parse); end
        checks++; if (at_data !== exp_data) begin errors++; $display("FAIL crc_hold got %h want %h", at_data, exp_data); end
    endtask

    task automatic test_parse_err();
        byte_q_t f;
        snap();
        send_byte(8'hFE, 1'b1);
        send_byte(8'h11, 1'b1);
        idle(4);
        #1;
        checks++; if (n_parse - s_parse !== 1) begin errors++; $display("FAIL parse_stx got %0d want 1", n_parse - s_parse); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL parse_idle got %b want 0", rx_busy); end
        f = '{8'hFE, 8'h05, 8'h4E, 8'h07};
        snap();
        send_frame(f, 1'b0);
        idle(4);
        #1;
        checks++; if (n_parse - s_parse !== 1 || n_trans - s_trans !== 0) begin errors++; $display("FAIL parse_len got parse %0d trans %0d want 1 0", n_parse - s_parse, n_trans - s_trans); end
    endtask

    task automatic test_frame_err();
        byte_q_t f;
        snap();
        send_byte(8'hFE, 1'b1);
        send_byte(8'h80, 1'b0);
        idle(4);
        #1;
        checks++; if (n_frame - s_frame !== 1 || n_parse - s_parse !== 0) begin errors++; $display("FAIL frame_err got frame %0d parse %0d want 1 0", n_frame - s_frame, n_parse - s_parse); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL frame_idle got %b want 0", rx_busy); end
        f = '{8'hFE, 8'h80, 8'h7F};
        snap();
        send_frame(f, 1'b1);
        idle(4);
        #1;
        checks++; if (n_trans - s_trans !== 1 || last_trans !== 3'd4) begin errors++; $display("FAIL frame_recover got n=%0d code=%0d want n=1 code=4", n_trans - s_trans, last_trans); end
    endtask

    task automatic test_abort(input bit use_reset);
        byte_q_t f;
        f = build_at(1'b1, 8'h4E, 24'h0BADF0, 1'b0);
        snap();
        // Send up through D0 plus the start bit and three data bits of D1
        for (int i = 0; i < 5; i++) send_byte(f[i], 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge sb_clk);
        sbrx = 1'b1;
        if (use_reset) begin
            rst = 1'b0;
            #1;
            exp_addr = 8'd0;
            exp_len  = 8'd0;
            exp_data = 24'd0;
            checks++; if (at_data !== 24'd0 || rx_busy !== 1'b0) begin errors++; $display("FAIL abort_async got data %h busy %b want 0 0", at_data, rx_busy); end
            @(negedge sb_clk);
            rst = 1'b1;
        end else begin
            rx_en = 1'b0;
            @(posedge sb_clk); #1;
            checks++; if (rx_busy !== 1'b0 || at_data !== exp_data) begin errors++; $display("FAIL abort_en got busy %b data %h want 0 %h", rx_busy, at_data, exp_data); end
            idle(3);
            rx_en = 1'b1;
        end
        idle(3);
        f = build_at(1'b1, 8'h4E, 24'hC0FFEE, 1'b0);
        send_frame(f, 1'b0);
        idle(4);
        #1;
        exp_addr = 8'h4E;
        exp_len  = 8'h03;
        exp_data = 24'hC0FFEE;
        checks++; if (n_trans - s_trans !== 1 || last_trans !== 3'd3) begin errors++; $display("FAIL abort_trans got n=%0d code=%0d want n=1 code=3", n_trans - s_trans, last_trans); end
        checks++; if (at_data !== exp_data) begin errors++; $display("FAIL abort_data got %h want %h", at_data, exp_data); end
        checks++; if (n_parse + n_crc + n_frame - s_parse - s_crc - s_frame !== 0) begin errors++; $display("FAIL abort_errs got %0d want 0", n_parse + n_crc + n_frame - s_parse - s_crc - s_frame); end
    endtask

    task automatic test_random();
        bit          rsp, bad;
        logic [7:0]  addr;
        logic [23:0] data;
        for (int it = 0; it < 16; it++) begin
            rsp  = 1'($urandom_range(0, 1));
            bad  = ($urandom_range(0, 3) == 0);
            addr = 8'($urandom);
            data = 24'($urandom);
            if ($urandom_range(0, 2) == 0) data[15:8] = 8'hFE;
            snap();
            send_frame(build_at(rsp, addr, data, bad), 1'b1);
            idle(4);
            #1;
            if (bad) begin
                checks++; if (n_crc - s_crc !== 1 || n_trans - s_trans !== 0) begin errors++; $display("FAIL rand_bad[%0d] got crc %0d trans %0d want 1 0", it, n_crc - s_crc, n_trans - s_trans); end
            end else begin
                exp_addr = addr;
                exp_len  = 8'h03;
                if (rsp) exp_data = data;
                checks++; if (n_trans - s_trans !== 1 || last_trans !== (rsp ? 3'd3 : 3'd2)) begin errors++; $display("FAIL rand_trans[%0d] got n=%0d code=%0d want n=1 code=%0d", it, n_trans - s_trans, last_trans, rsp ? 3 : 2); end
            end
            checks++; if (at_addr !== exp_addr || at_len !== exp_len || at_data !== exp_data) begin errors++; $display("FAIL rand_regs[%0d] got %h %h %h want %h %h %h", it, at_addr, at_len, at_data, exp_addr, exp_len, exp_data); end
        end
    endtask

    initial begin
        test_reset();
        test_lt();
        test_at_cmd();
        test_at_rsp();
        test_crc_err();
        test_parse_err();
        test_frame_err();
        test_abort(1'b0);
        test_abort(1'b1);
        test_random();
        #1;
        checks++; if (n_multi !== 0) begin errors++; $display("FAIL exclusive got %0d overlaps want 0", n_multi); end
        checks++; if (n_wide !== 0) begin errors++; $display("FAIL pulse_width got %0d wide pulses want 0", n_wide); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/transactions_rx_fsm.md
# transactions_rx_fsm

Sideband receive-side transaction parser, the counterpart of the sideband transaction generator. It deserializes the SBRX line (one bit per sb_clk, 10-bit frames: start 0, 8 data bits LSB first, stop 1) and recognizes DLE/STX/LSE/CLSE/ETX framing. It parses AT read commands, AT read responses and LT (LSE/CLSE) transactions, and checks the CRC-16. Results are reported to the control unit as one-cycle pulses plus held payload registers.

## Interface
- No parameters. Symbol constants are fixed:
  - DLE = 8'hFE, STX_CMD = 8'h05, STX_RSP = 8'h04, LSE = 8'h80, CLSE = 8'h7F, ETX = 8'h40.
  - Fixed AT address = 8'd78; fixed length byte = 8'h03.
- sb_clk   in   1   sideband clock, one line bit per cycle
- rst   in   1   asynchronous, active-low reset
- sbrx   in   1   serial sideband receive line, idle high
- rx_en   in   1   receiver enable; low forces both FSMs to IDLE and clears the bit counter
- trans_rcvd   out   3   one-cycle pulse with the transaction code: 3'd2 AT command, 3'd3 AT response, 3'd4 LT; 0 otherwise
- at_addr   out   8   address byte of the last good AT transaction
- at_len   out   8   length byte of the last good AT transaction
- at_data   out   24   response payload, first data byte in [23:16]; updated only on a good AT response
- crc_err   out   1   one-cycle pulse: AT frame completed with a CRC mismatch
- frame_err   out   1   one-cycle pulse: stop bit sampled 0
- parse_err   out   1   one-cycle pulse: unexpected symbol in the sequence
- rx_busy   out   1   high while the parser is outside IDLE

## Operation
- Deserializer FSM (states RX_IDLE, RX_BITS):
  - In RX_IDLE, with rx_en=1, sbrx=0 sampled → start bit; go to RX_BITS with bit_cnt=1.
  - bit_cnt 1..8 shift the data bits in LSB first. bit_cnt 9 samples the stop bit.
  - Stop bit = 1 → sym_valid pulse with sym[7:0]. Stop bit = 0 → frame_err pulse, parser forced to IDLE.
  - Either way the deserializer returns to RX_IDLE. A new start bit is accepted the cycle after the stop bit, so frames may be back-to-back.
- Parser FSM advances only on sym_valid. The legal sequences are:
  - IDLE: DLE → DLE1. Any other symbol → stay in IDLE, no error (line noise or idle).
  - DLE1: STX_CMD → CMD_ADDR; STX_RSP → RSP_ADDR; LSE → LSE_S. Anything else → parse_err, IDLE.
  - LSE_S: CLSE → trans_rcvd=4, IDLE. Anything else → parse_err, IDLE.
  - CMD_ADDR → CMD_LEN → CRC_HI (address and length bytes are captured into shadow registers).
  - RSP_ADDR → RSP_LEN → RSP_D0 → RSP_D1 → RSP_D2 → CRC_HI. The data bytes go to shadow data in [23:16], [15:8], [7:0].
  - Address bytes are any value. A length byte other than 8'h03 → parse_err, IDLE.
  - Data bytes are positional: a value of 8'hFE in the payload is data, not DLE. There is no DLE stuffing.
  - CRC_HI (capture rcv_crc[15:8]) → CRC_LO (capture rcv_crc[7:0]) → DLE2.
  - DLE2: DLE → ETX_S. Anything else → parse_err, IDLE.
  - ETX_S: ETX → compare the CRCs.
    - Match → trans_rcvd = 2 or 3; copy the shadow registers to at_addr/at_len (and at_data for a response).
    - Mismatch → crc_err, outputs unchanged.
    - Non-ETX → parse_err.
    - All three cases return to IDLE.
- CRC-16 rules:
  - Polynomial 16'h8005, initial value 16'hFFFF, no reflection, no final XOR.
  - Each byte is processed MSB first.
  - Coverage: the STX byte through the last address/length/data byte. DLE, CRC, and ETX bytes are excluded.
  - The CRC is reinitialized on entry to DLE1.
- At most one of trans_rcvd, crc_err, parse_err, frame_err is nonzero in any cycle.
- rx_busy = (parser state != IDLE).

## Timing
- Reset values:
  - All outputs are 0: trans_rcvd=0, at_addr=0, at_len=0, at_data=0, crc_err=0, frame_err=0, parse_err=0, rx_busy=0.
  - Both FSMs are in IDLE; CRC = 16'hFFFF.
- Latency: the stop bit of a symbol is sampled at edge N. sym_valid is high in the cycle after edge N. Parser outputs (trans_rcvd, the error pulses, the payload registers) update at edge N+1, so they are visible one cycle after the stop bit.
- Every pulse output is exactly one sb_clk wide.
- A frame of F symbols occupies 10·F cycles when sent back-to-back. Idle high bits between symbols are allowed in any amount.
- rx_en deasserted mid-frame: both FSMs go to IDLE at the next edge, no pulse is produced, and payload registers are held.
- Async reset mid-frame: everything returns to reset values immediately. The next valid frame must start with DLE.
- A frame_err in any parser state aborts the frame. frame_err takes priority, and no parse_err is raised for that symbol.

## Test plan
- LT: frames DLE, LSE, CLSE → trans_rcvd=3'd4 pulse one cycle after the CLSE stop bit; rx_busy high from after DLE until then.
- AT command: DLE, 05, 4E, 03, correct CRC (from the reference model), DLE, 40 → trans_rcvd=2, at_addr=8'h4E, at_len=8'h03, at_data unchanged.
- AT response: DLE, 04, 4E, 03, A5, FE, 3C, CRC, DLE, 40 → trans_rcvd=3, at_data=24'hA5FE3C. The 8'hFE data byte is not treated as DLE.
- Same AT response with CRC low byte XOR 8'h01 → crc_err pulse only, at_data retains its prior value.
- Errors:
  - DLE then 8'h11 → parse_err.
  - A frame with stop bit 0 → frame_err; the next valid LT frame is still decoded.
- Reset or rx_en=0 asserted during RSP_D1, then a clean AT response → only the second frame yields trans_rcvd=3.
